// File: rtl/keypad_digit_buffer_pkg.sv
// Shared keypad definitions: BCD digit type, its legal maximum and the
// digit-count width helper used by the keypad front end.
package keypad_digit_buffer_pkg;

    localparam int unsigned BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Bits needed to hold a digit count from 0 up to ndig inclusive.
    function automatic int unsigned count_width(input int unsigned ndig);
        return $clog2(ndig + 1);
    endfunction

endpackage

// File: rtl/keypad_digit_buffer_edge_detect.sv
// Falling-edge detector for an active-low keypad strobe, qualified by a
// level flag. Resets the history to 0 so a strobe held through reset never fires.
module keypad_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic strobe_n,
    input  logic qual,
    output logic ev_c
);

    logic strobe_n_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_n_q <= 1'b0;
        end else begin
            strobe_n_q <= strobe_n;
        end
    end

    // One cycle per high-to-low transition; an unqualified edge is simply lost.
    assign ev_c = strobe_n_q & ~strobe_n & qual;

endmodule

// File: rtl/keypad_digit_buffer.sv
// Calculator-style BCD entry register fed by the keypad encoder: shifts new
// digits in at nibble 0, supports clear and backspace, and flags full/overflow/bad codes.
module keypad_digit_buffer
    import keypad_digit_buffer_pkg::*;
#(
    parameter int unsigned NDIG      = 4,
    parameter bit          OVERWRITE = 1'b0,
    localparam int unsigned DW = BCD_W * NDIG,
    localparam int unsigned CW = count_width(NDIG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    code,
    input  logic          loadn,
    input  logic          pgt,
    input  logic          clr,
    input  logic          bksp,
    output logic [DW-1:0] digits,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          new_digit,
    output logic          overflow,
    output logic          err
);

    localparam logic [CW-1:0] CNT_MAX = CW'(NDIG);

    logic          load_ev_c;
    logic [DW-1:0] shifted_c;
    logic          code_ok_c;
    logic          has_room_c;
    logic [CW-1:0] count_inc_c;

    keypad_edge_detect u_edge (
        .clk      (clk),
        .reset    (reset),
        .strobe_n (loadn),
        .qual     (pgt),
        .ev_c     (load_ev_c)
    );

    // Truncating the concatenation drops the oldest nibble; also correct for NDIG=1.
    assign shifted_c   = DW'({digits, code});
    assign code_ok_c   = (bcd_t'(code) <= BCD_MAX);
    assign has_room_c  = (count < CNT_MAX);
    assign count_inc_c = count + CW'(1);

    // Entry state and one-cycle event pulses; priority reset > clr > load > bksp.
    always_ff @(posedge clk) begin
        if (reset) begin
            digits    <= '0;
            count     <= '0;
            full      <= 1'b0;
            new_digit <= 1'b0;
            overflow  <= 1'b0;
            err       <= 1'b0;
        end else begin
            new_digit <= 1'b0;
            overflow  <= 1'b0;
            err       <= 1'b0;
            if (clr) begin
                digits <= '0;
                count  <= '0;
                full   <= 1'b0;
            end else if (load_ev_c) begin
                if (!code_ok_c) begin
                    err <= 1'b1;
                end else if (has_room_c) begin
                    digits    <= shifted_c;
                    count     <= count_inc_c;
                    full      <= (count_inc_c == CNT_MAX);
                    new_digit <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                    if (OVERWRITE) begin
                        digits    <= shifted_c;
                        new_digit <= 1'b1;
                    end
                end
            end else if (bksp && (count != '0)) begin
                digits <= digits >> BCD_W;
                count  <= count - CW'(1);
                full   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_digit_buffer.sv
// Bench for keypad_digit_buffer: two instances (discard / overwrite when full)
// checked every cycle against an array-based digit-entry model.
module tb_keypad_digit_buffer;

    localparam int unsigned NDIG = 4;
    localparam int unsigned DW   = 16;
    localparam int unsigned CW   = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    code;
    logic          loadn;
    logic          pgt;
    logic          clr;
    logic          bksp;
    logic [DW-1:0] dig  [2];
    logic [CW-1:0] cnt  [2];
    logic          fl   [2];
    logic          nd   [2];
    logic          ov   [2];
    logic          er   [2];

    keypad_digit_buffer #(.NDIG(NDIG), .OVERWRITE(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .code(code), .loadn(loadn), .pgt(pgt),
        .clr(clr), .bksp(bksp), .digits(dig[0]), .count(cnt[0]), .full(fl[0]),
        .new_digit(nd[0]), .overflow(ov[0]), .err(er[0])
    );

    keypad_digit_buffer #(.NDIG(NDIG), .OVERWRITE(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .code(code), .loadn(loadn), .pgt(pgt),
        .clr(clr), .bksp(bksp), .digits(dig[1]), .count(cnt[1]), .full(fl[1]),
        .new_digit(nd[1]), .overflow(ov[1]), .err(er[1])
    );

    always #5 clk = ~clk;

    // Model: md[w][0] is the most recent digit, mc[w] the number held.
    int md [2][NDIG];
    int mc [2];
    bit e_nd [2];
    bit e_ov [2];
    bit e_err;
    bit prev_loadn;
    bit started;
    int vectors;
    int miscompares;
    int ndc [2];
    int ovc [2];
    int erc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_digits(input int w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < NDIG; i++) v = v | (64'(md[w][i]) << (4 * i));
        return v;
    endfunction

    task automatic model_step();
        bit ev;
        ev = prev_loadn && !loadn && pgt;
        prev_loadn = reset ? 1'b0 : loadn;
        if (reset) started = 1'b1;
        e_err = 1'b0;
        for (int w = 0; w < 2; w++) begin
            e_nd[w] = 1'b0;
            e_ov[w] = 1'b0;
            if (reset || clr) begin
                for (int i = 0; i < NDIG; i++) md[w][i] = 0;
                mc[w] = 0;
            end else if (ev) begin
                if (int'(code) > 9) begin
                    e_err = 1'b1;
                end else if (mc[w] < NDIG || w == 1) begin
                    if (mc[w] == NDIG) e_ov[w] = 1'b1;
                    else mc[w] = mc[w] + 1;
                    for (int i = NDIG - 1; i > 0; i--) md[w][i] = md[w][i-1];
                    md[w][0] = int'(code);
                    e_nd[w] = 1'b1;
                end else begin
                    e_ov[w] = 1'b1;
                end
            end else if (bksp && mc[w] > 0) begin
                for (int i = 0; i < NDIG - 1; i++) md[w][i] = md[w][i+1];
                md[w][NDIG-1] = 0;
                mc[w] = mc[w] - 1;
            end
        end
    endtask

    // One clock: update model at the edge, compare just after, return at negedge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (started) begin
            for (int w = 0; w < 2; w++) begin
                chk($sformatf("digits%0d", w), 64'(dig[w]), model_digits(w));
                chk($sformatf("count%0d", w), 64'(cnt[w]), 64'(mc[w]));
                chk($sformatf("full%0d", w), 64'(fl[w]), 64'(mc[w] == NDIG));
                chk($sformatf("new_digit%0d", w), 64'(nd[w]), 64'(e_nd[w]));
                chk($sformatf("overflow%0d", w), 64'(ov[w]), 64'(e_ov[w]));
                chk($sformatf("err%0d", w), 64'(er[w]), 64'(e_err));
                ndc[w] += int'(nd[w] === 1'b1);
                ovc[w] += int'(ov[w] === 1'b1);
            end
            erc += int'(er[0] === 1'b1);
        end
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] c);
        loadn = 1'b0;
        code  = c;
        pgt   = 1'b1;
        repeat (10) tick();
        loadn = 1'b1;
        repeat (2) tick();
    endtask

    task automatic backspace();
        bksp = 1'b1;
        tick();
        bksp = 1'b0;
        tick();
    endtask

    initial begin
        int nd0, ov0, nd1, ov1, e0;
        reset = 1'b1; loadn = 1'b0; pgt = 1'b1; code = 4'd5; clr = 1'b0; bksp = 1'b0;
        @(negedge clk);
        repeat (3) tick();
        chk("reset_digits", 64'(dig[0]), 64'h0);
        chk("reset_full", 64'(fl[0]), 64'h0);

        // Key held through reset must not be captured.
        reset = 1'b0;
        repeat (10) tick();
        chk("held_digits", 64'(dig[0]), 64'h0);
        chk("held_count", 64'(cnt[0]), 64'h0);
        loadn = 1'b1;
        repeat (2) tick();

        nd0 = ndc[0];
        press(4'd9); press(4'd8); press(4'd7);
        chk("seq_digits", 64'(dig[0]), 64'h0987);
        chk("seq_count", 64'(cnt[0]), 64'd3);
        chk("seq_full", 64'(fl[0]), 64'h0);
        chk("seq_pulses", 64'(ndc[0] - nd0), 64'd3);

        backspace();
        chk("bksp1_digits", 64'(dig[0]), 64'h0098);
        backspace();
        chk("bksp2_digits", 64'(dig[0]), 64'h0009);
        chk("bksp2_count", 64'(cnt[0]), 64'd1);
        backspace();
        nd0 = ndc[0];
        backspace();
        chk("bksp_empty_digits", 64'(dig[0]), 64'h0);
        chk("bksp_empty_pulse", 64'(ndc[0] - nd0), 64'd0);

        e0 = erc;
        press(4'hA);
        chk("err_pulses", 64'(erc - e0), 64'd1);
        chk("err_digits", 64'(dig[0]), 64'h0);
        chk("err_count", 64'(cnt[0]), 64'd0);

        // Load and backspace on the same edge: load wins.
        press(4'd1); press(4'd2);
        loadn = 1'b0; code = 4'd3; bksp = 1'b1;
        tick();
        bksp = 1'b0;
        repeat (4) tick();
        loadn = 1'b1;
        repeat (2) tick();
        chk("ldbk_digits", 64'(dig[0]), 64'h0123);
        chk("ldbk_count", 64'(cnt[0]), 64'd3);

        // Clear during the falling edge: that press is lost.
        loadn = 1'b0; code = 4'd5; clr = 1'b1;
        repeat (2) tick();
        clr = 1'b0;
        repeat (5) tick();
        loadn = 1'b1;
        repeat (2) tick();
        chk("clr_digits", 64'(dig[0]), 64'h0);
        chk("clr_count", 64'(cnt[0]), 64'd0);

        press(4'd9); press(4'd8); press(4'd7); press(4'd6);
        chk("full_flag", 64'(fl[0]), 64'h1);
        nd0 = ndc[0]; ov0 = ovc[0]; nd1 = ndc[1]; ov1 = ovc[1];
        press(4'd5);
        chk("ovf0_digits", 64'(dig[0]), 64'h9876);
        chk("ovf0_full", 64'(fl[0]), 64'h1);
        chk("ovf0_ov_pulses", 64'(ovc[0] - ov0), 64'd1);
        chk("ovf0_nd_pulses", 64'(ndc[0] - nd0), 64'd0);
        chk("ovf1_digits", 64'(dig[1]), 64'h8765);
        chk("ovf1_count", 64'(cnt[1]), 64'd4);
        chk("ovf1_ov_pulses", 64'(ovc[1] - ov1), 64'd1);
        chk("ovf1_nd_pulses", 64'(ndc[1] - nd1), 64'd1);

        // Randomised traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 3) == 0) loadn = ~loadn;
            pgt   = ($urandom_range(0, 7) != 0);
            code  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15))
                                                 : 4'($urandom_range(0, 9));
            clr   = ($urandom_range(0, 39) == 0);
            bksp  = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
